adder_result_collector: RTL and testbench

- Downstream consumer of the 8-bit two-nibble ripple adder: captures each {Cout, Sum} result into a small show-ahead FIFO.
- Keeps a running accumulation of captured results with a sticky overflow flag.
- Issues a block-complete pulse every BLOCK_LEN captured results.
- Decouples the combinational adder from a slower sink through valid/ready handshakes on both sides.

---
 rtl/adder_result_collector.sv | 165 ++++++++++++++++
 tb/tb_adder_result_collector.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_collector.sv
// Collects {cout,sum} results from the two-nibble ripple adder into a show-ahead FIFO,
// keeping a running accumulation with sticky overflow and a per-block completion pulse.
module adder_result_collector #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned BLOCK_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_W-1:0]        in_sum_i,
    input  logic                     in_cout_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W:0]          out_word_o,
    input  logic                     acc_clear_i,
    output logic [ACC_W-1:0]         acc_o,
    output logic                     acc_ovf_o,
    output logic                     blk_done_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned LvlW    = PtrW + 1;
    localparam int unsigned WordW   = DATA_W + 1;
    localparam int unsigned AccPadW = ACC_W - WordW;
    localparam int unsigned CntW    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic [WordW-1:0]  mem_q [DEPTH];
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              blk_done_q, blk_done_d;

    logic              push;
    logic              pop;
    logic [WordW-1:0]  in_word;
    logic [ACC_W-1:0]  acc_base;
    logic [CntW-1:0]   cnt_base;
    logic [ACC_W:0]    acc_sum;

    assign in_word = {in_cout_i, in_sum_i};
    assign push    = in_valid_i & in_ready_o;
    assign pop     = out_valid_o & out_ready_i;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: occupancy class derived from level and handshakes
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StPartial;
                end
            end
            StPartial: begin
                if (push && !pop && level_q == LvlW'(DEPTH - 1)) begin
                    state_d = StFull;
                end else if (pop && !push && level_q == LvlW'(1)) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    state_d = StPartial;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // FSM outputs: decoded from registered state only
    always_comb begin
        in_ready_o  = (state_q != StFull);
        out_valid_o = (state_q != StEmpty);
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the empty state masks the head to zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

    // Clear takes effect before a same-cycle accept is added in.
    always_comb begin
        acc_base   = acc_clear_i ? '0 : acc_q;
        cnt_base   = acc_clear_i ? '0 : cnt_q;
        acc_sum    = {1'b0, acc_base} + {1'b0, {AccPadW{1'b0}}, in_word};
        acc_d      = acc_base;
        ovf_d      = acc_clear_i ? 1'b0 : ovf_q;
        cnt_d      = cnt_base;
        blk_done_d = 1'b0;
        if (push) begin
            acc_d = acc_sum[ACC_W-1:0];
            ovf_d = ovf_d | acc_sum[ACC_W];
            if (cnt_base == CntW'(BLOCK_LEN - 1)) begin
                cnt_d      = '0;
                blk_done_d = 1'b1;
            end else begin
                cnt_d = cnt_base + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            blk_done_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            blk_done_q <= blk_done_d;
        end
    end

    assign out_word_o = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign acc_o      = acc_q;
    assign acc_ovf_o  = ovf_q;
    assign blk_done_o = blk_done_q;
    assign level_o    = level_q;

endmodule

// File: tb/tb_adder_result_collector.sv
// Bench for adder_result_collector: vector table plus hand sequences, checked against a
// queue-based reference model every cycle.
module tb_adder_result_collector;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int ACC_W     = 16;
    localparam int BLOCK_LEN = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_sum;
    logic                 in_cout;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W:0]      out_word;
    logic                 acc_clear;
    logic [ACC_W-1:0]     acc;
    logic                 acc_ovf;
    logic                 blk_done;
    logic [2:0]           level;

    adder_result_collector #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ACC_W     (ACC_W),
        .BLOCK_LEN (BLOCK_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_sum_i    (in_sum),
        .in_cout_i   (in_cout),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_word_o  (out_word),
        .acc_clear_i (acc_clear),
        .acc_o       (acc),
        .acc_ovf_o   (acc_ovf),
        .blk_done_o  (blk_done),
        .level_o     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model
    logic [8:0]  sb[$];
    int          m_level;
    logic [15:0] m_acc;
    bit          m_ovf;
    int          m_cnt;
    bit          m_blk;

    typedef struct {
        logic        v;
        logic [7:0]  sum;
        logic        cout;
        logic        rdy;
        logic        clr;
        int          exp_level;
        logic [15:0] exp_acc;
        logic [8:0]  exp_word;
        logic        exp_blk;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_level = 0;
        m_acc   = '0;
        m_ovf   = 0;
        m_cnt   = 0;
        m_blk   = 0;
    endtask

    task automatic check_now();
        logic [8:0] head;
        head = (sb.size() != 0) ? sb[0] : 9'h000;
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_level != DEPTH});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_level != 0});
        chk("out_word", {23'b0, out_word}, {23'b0, head});
        chk("level", {29'b0, level}, m_level);
        chk("acc", {16'b0, acc}, {16'b0, m_acc});
        chk("acc_ovf", {31'b0, acc_ovf}, {31'b0, m_ovf});
        chk("blk_done", {31'b0, blk_done}, {31'b0, m_blk});
    endtask

    // Check current outputs, advance the model by one edge, then cross the edge.
    task automatic tick();
        bit          acc_in;
        bit          do_pop;
        bit          blk;
        logic [16:0] s;
        check_now();
        acc_in = in_valid && (m_level < DEPTH);
        do_pop = (m_level > 0) && out_ready;
        blk    = 0;
        if (acc_clear) begin
            m_acc = '0;
            m_ovf = 0;
            m_cnt = 0;
        end
        if (acc_in) begin
            s     = {1'b0, m_acc} + {8'b0, in_cout, in_sum};
            m_acc = s[15:0];
            if (s[16]) m_ovf = 1;
            m_cnt++;
            if (m_cnt == BLOCK_LEN) begin
                m_cnt = 0;
                blk   = 1;
            end
        end
        m_blk = blk;
        if (do_pop) void'(sb.pop_front());
        if (acc_in) sb.push_back({in_cout, in_sum});
        m_level = sb.size();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] w, input logic r, input logic c);
        in_valid  = v;
        in_cout   = w[8];
        in_sum    = w[7:0];
        out_ready = r;
        acc_clear = c;
    endtask

    task automatic drain();
        drive(1'b0, 9'h000, 1'b1, 1'b0);
        for (int k = 0; k < 16 && m_level != 0; k++) tick();
        chk("drain level", {29'b0, level}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h3E, 1'b1, 1'b0, 1'b0, 1, 16'h013E, 9'h13E, 1'b0};
        vecs[1]  = '{1'b1, 8'h7C, 1'b1, 1'b0, 1'b0, 2, 16'h02BA, 9'h13E, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 16'h02BA, 9'h17C, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 16'h02BA, 9'h000, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 9'h000, 1'b0};
        vecs[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1, 16'h0001, 9'h001, 1'b0};
        vecs[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 2, 16'h0002, 9'h001, 1'b0};
        vecs[7]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 3, 16'h0003, 9'h001, 1'b0};
        vecs[8]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4, 16'h0004, 9'h001, 1'b1};
        vecs[9]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4, 16'h0004, 9'h001, 1'b0};
        vecs[10] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 3, 16'h0004, 9'h001, 1'b0};
        vecs[11] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 3, 16'h0005, 9'h001, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2, 16'h0005, 9'h001, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 16'h0005, 9'h001, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 16'h0005, 9'h000, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        model_reset();
        #2;
        check_now();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, {vecs[i].cout, vecs[i].sum}, vecs[i].rdy, vecs[i].clr);
            tick();
            chk($sformatf("vec%0d level", i), {29'b0, level}, vecs[i].exp_level);
            chk($sformatf("vec%0d acc", i), {16'b0, acc}, {16'b0, vecs[i].exp_acc});
            chk($sformatf("vec%0d word", i), {23'b0, out_word}, {23'b0, vecs[i].exp_word});
            chk($sformatf("vec%0d blk", i), {31'b0, blk_done}, {31'b0, vecs[i].exp_blk});
        end

        // Overflow: 256 accepts of 0x1FF wrap the accumulator
        drive(1'b0, 9'h000, 1'b0, 1'b1);
        tick();
        drive(1'b1, 9'h1FF, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) tick();
        chk("ovf acc", {16'b0, acc}, 32'h0000_FF00);
        chk("ovf flag", {31'b0, acc_ovf}, 32'd1);
        drive(1'b0, 9'h000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        chk("ovf sticky", {31'b0, acc_ovf}, 32'd1);
        drive(1'b1, 9'h005, 1'b0, 1'b1);
        tick();
        chk("clr+acc acc", {16'b0, acc}, 32'h0000_0005);
        chk("clr+acc ovf", {31'b0, acc_ovf}, 32'd0);
        drain();

        // Reset mid-stream with level 3 and acc 0x123
        drive(1'b0, 9'h000, 1'b0, 1'b1);
        tick();
        drive(1'b1, 9'h100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 9'h020, 1'b0, 1'b0);
        tick();
        drive(1'b1, 9'h003, 1'b0, 1'b0);
        tick();
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        chk("pre-rst level", {29'b0, level}, 32'd3);
        chk("pre-rst acc", {16'b0, acc}, 32'h0000_0123);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst out_word", {23'b0, out_word}, 32'd0);
        chk("rst acc", {16'b0, acc}, 32'd0);
        chk("rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst level", {29'b0, level}, 32'd0);
        model_reset();
        check_now();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 9'h0AA, 1'b0, 1'b0);
        tick();
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        chk("post-rst word", {23'b0, out_word}, 32'h0000_00AA);
        chk("post-rst acc", {16'b0, acc}, 32'h0000_00AA);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
